// File: rtl/us_burst_scheduler.sv
// Three-channel ultrasonic burst scheduler: free-running carrier, per-channel
// phase offsets and ON/OFF burst gating, with registered drive outputs.

module us_burst_lane #(
  parameter int PERIOD = 678,
  parameter int PW     = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [PW-1:0] ctr,
  input  logic [PW-1:0] phase,
  output logic          a,
  output logic          b
);
  logic [PW:0] d;
  logic        wave;

  // (ctr - phase) mod PERIOD without a divider
  always_comb begin
    if (ctr >= phase) d = {1'b0, ctr} - {1'b0, phase};
    else              d = {1'b0, ctr} + (PW+1)'(PERIOD) - {1'b0, phase};
    wave = d < (PW+1)'(PERIOD / 2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a <= 1'b0;
      b <= 1'b0;
    end else begin
      a <= run & wave;
      b <= run & ~wave;
    end
  end
endmodule

module us_burst_scheduler #(
  parameter int PERIOD = 678,
  parameter int NCH    = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  output logic             cfg_err,
  input  logic             start,
  input  logic             stop,
  input  logic             mute,
  output logic [NCH-1:0]   ch_a,
  output logic [NCH-1:0]   ch_b,
  output logic             busy,
  output logic             wrap,
  output logic             burst_done
);
  localparam int PW = $clog2(PERIOD);
  localparam logic [2:0] A_ON  = 3'd3;
  localparam logic [2:0] A_OFF = 3'd4;
  localparam logic [2:0] A_CNT = 3'd5;

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  state_t state, nxt;

  logic [PW-1:0]          ctr;
  logic                   armed;
  logic [NCH-1:0][PW-1:0] phase_sh, phase_act;
  logic [CNT_W-1:0]       on_cfg, off_cfg, cnt_cfg;
  logic [CNT_W-1:0]       on_act, off_act, cnt_act;
  logic [CNT_W-1:0]       per_cnt, bursts, per_inc, bursts_inc;
  logic                   start_pend, stop_pend, start_eff, stop_eff;
  logic                   clr_per, clr_bursts, inc_per, inc_bursts, latch_cfg, done_nxt;
  logic                   ph_ok, cfg_bad;

  assign wrap    = (ctr == '0) && armed;
  assign busy    = (state != IDLE);
  assign ph_ok   = cfg_wdata < CNT_W'(PERIOD);
  assign cfg_bad = cfg_we && (((cfg_addr < 3'(NCH)) && !ph_ok) || (cfg_addr > A_CNT));

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr   <= '0;
      armed <= 1'b0;
    end else begin
      ctr   <= (ctr == PW'(PERIOD - 1)) ? '0 : ctr + 1'b1;
      armed <= 1'b1;
    end
  end

  // Phase writes land in the shadow; the active copy only moves on a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_sh  <= '0;
      phase_act <= '0;
      on_cfg    <= CNT_W'(10);
      off_cfg   <= CNT_W'(10);
      cnt_cfg   <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_bad;
      if (wrap) phase_act <= phase_sh;
      if (cfg_we && !cfg_bad) begin
        for (int i = 0; i < NCH; i++)
          if (cfg_addr == 3'(i)) phase_sh[i] <= cfg_wdata[PW-1:0];
        if (cfg_addr == A_ON)  on_cfg  <= cfg_wdata;
        if (cfg_addr == A_OFF) off_cfg <= cfg_wdata;
        if (cfg_addr == A_CNT) cnt_cfg <= cfg_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt        = state;
    clr_per    = 1'b0;
    clr_bursts = 1'b0;
    inc_per    = 1'b0;
    inc_bursts = 1'b0;
    latch_cfg  = 1'b0;
    done_nxt   = 1'b0;
    start_eff  = start_pend | (start & (state == IDLE));
    stop_eff   = stop_pend | stop;
    per_inc    = per_cnt + 1'b1;
    bursts_inc = bursts + 1'b1;
    if (wrap) begin
      case (state)
        IDLE: if (start_eff && !stop_eff) begin
          if (on_cfg != '0) begin
            nxt        = ON;
            clr_per    = 1'b1;
            clr_bursts = 1'b1;
            latch_cfg  = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end
        ON: if (stop_eff) begin
          nxt      = IDLE;
          done_nxt = 1'b1;
        end else if (per_inc >= on_act) begin
          inc_bursts = 1'b1;
          clr_per    = 1'b1;
          if (cnt_act != '0 && bursts_inc == cnt_act) begin
            nxt      = IDLE;
            done_nxt = 1'b1;
          end else if (off_act != '0) begin
            nxt       = OFF;
            latch_cfg = 1'b1;
          end
        end else begin
          inc_per = 1'b1;
        end
        OFF: if (stop_eff) begin
          nxt      = IDLE;
          done_nxt = 1'b1;
        end else if (per_inc >= off_act) begin
          nxt       = ON;
          clr_per   = 1'b1;
          latch_cfg = 1'b1;
        end else begin
          inc_per = 1'b1;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // Burst lengths are snapshotted at each transition so a write never disturbs a running count.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt    <= '0;
      bursts     <= '0;
      on_act     <= CNT_W'(10);
      off_act    <= CNT_W'(10);
      cnt_act    <= '0;
      start_pend <= 1'b0;
      stop_pend  <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= done_nxt;
      if (clr_per)      per_cnt <= '0;
      else if (inc_per) per_cnt <= per_inc;
      if (clr_bursts)      bursts <= '0;
      else if (inc_bursts) bursts <= bursts_inc;
      if (latch_cfg) begin
        on_act  <= on_cfg;
        off_act <= off_cfg;
        cnt_act <= cnt_cfg;
      end
      start_pend <= wrap ? 1'b0 : start_eff;
      stop_pend  <= wrap ? 1'b0 : stop_eff;
    end
  end

  // Lanes see the post-decision state so the ctr == 0 sample belongs to the new phase.
  logic run;
  assign run = (nxt == ON) && !mute;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    us_burst_lane #(.PERIOD(PERIOD), .PW(PW)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .run  (run),
      .ctr  (ctr),
      .phase(phase_act[i]),
      .a    (ch_a[i]),
      .b    (ch_b[i])
    );
  end
endmodule

// File: tb/tb_us_burst_scheduler.sv
// Bench for us_burst_scheduler: per-cycle comparison against a period-queue
// reference model, plus directed burst-length totals.

module tb_us_burst_scheduler;
  localparam int P   = 678;
  localparam int NCH = 3;
  localparam int CW  = 16;

  logic           clk = 1'b0;
  logic           rst, cfg_we, start, stop, mute;
  logic [2:0]     cfg_addr;
  logic [CW-1:0]  cfg_wdata;
  logic           cfg_err, busy, wrap, burst_done;
  logic [NCH-1:0] ch_a, ch_b;

  us_burst_scheduler #(.PERIOD(P), .NCH(NCH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_err(cfg_err), .start(start), .stop(stop), .mute(mute), .ch_a(ch_a), .ch_b(ch_b),
    .busy(busy), .wrap(wrap), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a sequence is a queue of period kinds (1 = ON, 2 = OFF, 3 = end).
  int m_ctr, m_cur, m_on, m_off, m_cnt, s_on, s_off, s_cnt, m_gen;
  bit m_first, m_busy, m_sp, m_pp;
  int sh [NCH];
  int act [NCH];
  int q [$];
  logic [NCH-1:0] e_a, e_b;
  bit e_busy, e_wrap, e_done, e_err;

  task automatic refill();
    m_gen++;
    repeat (s_on) q.push_back(1);
    if (s_cnt != 0 && m_gen == s_cnt) q.push_back(3);
    else repeat (s_off) q.push_back(2);
  endtask

  task automatic model_step();
    bit w, s_eff, p_eff, wv;
    int d;
    if (rst) begin
      m_ctr = 0; m_first = 1; m_cur = 0; m_busy = 0; m_sp = 0; m_pp = 0;
      m_on = 10; m_off = 10; m_cnt = 0; q.delete();
      for (int i = 0; i < NCH; i++) begin sh[i] = 0; act[i] = 0; end
      e_a = '0; e_b = '0; e_busy = 0; e_wrap = 0; e_done = 0; e_err = 0;
      return;
    end
    w = (m_ctr == 0) && !m_first;
    s_eff = m_sp || (start && !m_busy);
    p_eff = m_pp || stop;
    e_done = 0;
    if (w) begin
      if (m_busy) begin
        if (p_eff) begin
          m_cur = 0; q.delete(); e_done = 1;
        end else begin
          if (q.size() == 0) refill();
          m_cur = q.pop_front();
          if (m_cur == 3) begin m_cur = 0; q.delete(); e_done = 1; end
        end
      end else if (s_eff && !p_eff) begin
        if (m_on == 0) e_done = 1;
        else begin
          s_on = m_on; s_off = m_off; s_cnt = m_cnt; m_gen = 0; q.delete();
          refill();
          m_cur = q.pop_front();
        end
      end
      m_sp = 0; m_pp = 0;
    end else begin
      m_sp = s_eff; m_pp = p_eff;
    end
    for (int i = 0; i < NCH; i++) begin
      d = (m_ctr - act[i] + P) % P;
      wv = d < P / 2;
      e_a[i] = (m_cur == 1) && !mute && wv;
      e_b[i] = (m_cur == 1) && !mute && !wv;
    end
    e_busy = m_cur != 0;
    e_wrap = m_ctr == P - 1;
    e_err = cfg_we && ((int'(cfg_addr) < NCH && int'(cfg_wdata) >= P) || cfg_addr > 5);
    if (w) for (int i = 0; i < NCH; i++) act[i] = sh[i];
    if (cfg_we && !e_err) begin
      if (int'(cfg_addr) < NCH) sh[cfg_addr] = int'(cfg_wdata);
      else if (cfg_addr == 3) m_on = int'(cfg_wdata);
      else if (cfg_addr == 4) m_off = int'(cfg_wdata);
      else if (cfg_addr == 5) m_cnt = int'(cfg_wdata);
    end
    m_ctr = (m_ctr + 1) % P;
    m_first = 0;
    m_busy = m_cur != 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("ch_a", 32'(ch_a), 32'(e_a));
    chk("ch_b", 32'(ch_b), 32'(e_b));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("wrap", 32'(wrap), 32'(e_wrap));
    chk("burst_done", 32'(burst_done), 32'(e_done));
    chk("cfg_err", 32'(cfg_err), 32'(e_err));
  endtask

  task automatic wr(input int addr, input int data);
    cfg_we = 1; cfg_addr = 3'(addr); cfg_wdata = CW'(data);
    tick();
    cfg_we = 0;
  endtask

  task automatic pulse_start(); start = 1; tick(); start = 0; endtask
  task automatic pulse_stop();  stop = 1;  tick(); stop = 0;  endtask
  task automatic run(input int n); repeat (n) tick(); endtask
  task automatic wait_ctr(input int c); repeat (P) if (m_ctr != c) tick(); endtask

  initial begin
    int nb, nd, hi, guard;
    rst = 1; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0; start = 0; stop = 0; mute = 0;
    run(3);
    rst = 0;
    run(5);

    // Two bursts of 2 ON / 3 OFF periods, started mid-period.
    wr(3, 2); wr(4, 3); wr(5, 2);
    wait_ctr(100);
    pulse_start();
    nb = 0; nd = 0; hi = 0;
    repeat (9 * P) begin
      tick();
      nb += int'(busy); nd += int'(burst_done); hi += int'(ch_a[0]);
    end
    chk("busy_len", nb, 7 * P);
    chk("done_cnt", nd, 1);
    chk("ch_a0_high", hi, 4 * (P / 2));

    // Continuous carrier, phase update, rejected writes, ignored start, mute, stop mid-period.
    wr(3, 1); wr(4, 0); wr(5, 0);
    pulse_start();
    run(P + 50);
    wr(1, 169); wr(2, 339);
    wr(0, 678); wr(7, 5); wr(6, 5);
    run(2 * P);
    pulse_start();
    run(200);
    mute = 1; run(50); mute = 0;
    run(P);
    wait_ctr(300);
    pulse_stop();
    nd = 0;
    repeat (2 * P) begin tick(); nd += int'(burst_done); end
    chk("stop_done_cnt", nd, 1);

    // start and stop together while idle: nothing happens.
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    nb = 0;
    repeat (2 * P) begin tick(); nb += int'(busy) + int'(ch_a != 0); end
    chk("start_stop_idle", nb, 0);

    // Reset in the middle of an OFF phase.
    wr(3, 1); wr(4, 3); wr(5, 0);
    pulse_start();
    guard = 0;
    while (m_cur != 2 && guard < 4 * P) begin tick(); guard++; end
    chk("reached_off", m_cur, 2);
    run(100);
    rst = 1; tick(); rst = 0;
    run(10);

    // Defaults after reset: 10 ON / 10 OFF, repeat until stop.
    pulse_start();
    run(12 * P);
    pulse_stop();
    run(2 * P);

    // Randomized sequences.
    for (int r = 0; r < 5; r++) begin
      wr(3, $urandom_range(0, 3)); wr(4, $urandom_range(0, 2)); wr(5, $urandom_range(0, 3));
      for (int c = 0; c < NCH; c++)
        wr(c, ($urandom_range(0, 4) == 0) ? $urandom_range(P, 2000) : $urandom_range(0, P - 1));
      run($urandom_range(0, P - 1));
      pulse_start();
      for (int k = 0; k < 6; k++) begin
        run($urandom_range(P / 2, P));
        if ($urandom_range(0, 2) == 0) begin mute = 1; run($urandom_range(1, 60)); mute = 0; end
        if ($urandom_range(0, 3) == 0) pulse_start();
        if ($urandom_range(0, 5) == 0) wr($urandom_range(0, NCH - 1), $urandom_range(0, P - 1));
      end
      pulse_stop();
      run(2 * P);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
